// File: rtl/pt2262_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pt2262_pkg
// Description : Shared types and constants for the PT2262-compatible encoder:
//               trit codes, FSM state encoding, segment lengths (in units of
//               the protocol period "a") and word geometry.
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
package pt2262_pkg;

    // Two-bit trit codes as presented on a_i (01 is not a legal trit)
    localparam logic [1:0] TRIT_0 = 2'b00;
    localparam logic [1:0] TRIT_1 = 2'b11;
    localparam logic [1:0] TRIT_F = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BITS = 2'd2,
        ST_SYNC = 2'd3
    } state_t;

    // Segment lengths in units of a
    localparam logic [6:0] SEG_SHORT    = 7'd4;
    localparam logic [6:0] SEG_LONG     = 7'd12;
    localparam logic [6:0] SEG_SYNC_LOW = 7'd124;

    // Word geometry: 8 address trits + 4 data bits, 4 segments per code bit
    localparam int         SYMBOLS  = 12;
    localparam int         SEGMENTS = 4;
    localparam logic [3:0] SYM_LAST = 4'(SYMBOLS - 1);
    localparam logic [1:0] SEG_LAST = 2'(SEGMENTS - 1);
    localparam logic [3:0] SYM_DATA = 4'd8;

    // Length (in a) of segment seg (0..3) of a code bit carrying trit.
    // A code bit is two halves; each half is "short-high/long-low" (a 0-half)
    // or "long-high/short-low" (a 1-half). 0 = 0,0; 1 = 1,1; F = 0,1.
    // The second half tests trit != 0 so an illegal 01 is sent exactly as F.
    function automatic logic [6:0] code_seg_units(input logic [1:0] trit,
                                                  input logic [1:0] seg);
        logic one_half;
        one_half = seg[1] ? (trit != TRIT_0) : (trit == TRIT_1);
        if (seg[0] == 1'b0)
            return one_half ? SEG_LONG : SEG_SHORT;
        else
            return one_half ? SEG_SHORT : SEG_LONG;
    endfunction

    // True when any of the 8 address trits carries the illegal 01 code
    function automatic logic has_invalid_trit(input logic [15:0] a);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (a[2*k +: 2] == 2'b01)
                bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pt2262_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : pt2262_encoder_if
// Description : Signal bundle between a word source and the PT2262 encoder.
//               master : drives a_i, d_i, te_i; observes the status outputs.
//               slave  : the encoder itself.
//   a_i[15:0]   address trits, trit k = a_i[2k+1:2k]
//   d_i[3:0]    data bits
//   te_i        transmit enable (level)
//   cod_o       encoded serial line
//   busy_o      transmission in progress
//   word_done_o one-clk pulse at the end of each word
//   err_o       one-clk pulse on an illegal trit (check build only)
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
interface pt2262_encoder_if;
    logic [15:0] a_i;
    logic [3:0]  d_i;
    logic        te_i;
    logic        cod_o;
    logic        busy_o;
    logic        word_done_o;
    logic        err_o;

    modport master (
        output a_i, d_i, te_i,
        input  cod_o, busy_o, word_done_o, err_o
    );

    modport slave (
        input  a_i, d_i, te_i,
        output cod_o, busy_o, word_done_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/pt2262_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pt2262_tick_gen
// Description : Oscillator tick divider. Counts 0..DIV-1 and asserts o_tick
//               for one clk while the count sits at DIV-1. i_clr holds the
//               count at zero and masks the tick.
//   clk     system clock
//   reset   synchronous active-high reset
//   i_clr   synchronous clear
//   o_tick  one-clk tick enable
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
module pt2262_tick_gen #(
    parameter int DIV = 250
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clr,
    output logic      o_tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (r_cnt == c_last)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_tick = !i_clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/pt2262_encoder.sv
`default_nettype none
// ============================================================================
// Module      : pt2262_encoder
// Description : PT2262-compatible serial encoder. Sends 8 address trits,
//               4 data bits and a sync symbol on cod_o, repeating words while
//               te_i is high and always sending at least MIN_WORDS words.
//   clk    system clock (3 MHz nominal)
//   reset  synchronous active-high reset
//   bus    pt2262_encoder_if.slave (a_i, d_i, te_i, cod_o, busy_o,
//          word_done_o, err_o)
// Macros      : PT2262_INVALID_TRIT_CHECK_EN - reject words containing an
//               illegal 01 trit (err_o pulse, nothing sent). Undefined: err_o
//               stays 0 and 01 is sent as F.
// Revision    : 1.0 - initial release
// ============================================================================
module pt2262_encoder
    import pt2262_pkg::*;
#(
    parameter int DIV       = 250,
    parameter int A_TICKS   = 4,
    parameter int MIN_WORDS = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pt2262_encoder_if.slave   bus
);

    localparam int TW = $clog2(int'(SEG_SYNC_LOW) * A_TICKS + 1);
    localparam int WW = (MIN_WORDS > 0) ? $clog2(MIN_WORDS + 1) : 1;
    localparam logic [WW-1:0] c_min_words = WW'(MIN_WORDS);

    state_t        r_state, w_state_next;
    logic [15:0]   r_a;
    logic [3:0]    r_d;
    logic [3:0]    r_sym, w_sym_next;
    logic [1:0]    r_seg, w_seg_next;
    logic [TW-1:0] r_tcnt, w_tcnt_next;
    logic [WW-1:0] r_words, w_words_next, w_words_inc;
    logic          r_cod, w_cod_next;
    logic          r_done, w_done_next;
    logic          r_err, w_err_next;
    logic          w_latch, w_div_clr, w_tick;
    logic [1:0]    w_trit;
    logic [6:0]    w_units;
    logic [TW-1:0] w_seg_ticks;
    logic          w_seg_end;

    pt2262_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_div_clr),
        .o_tick (w_tick)
    );

    // Data bits are sent as the full-valued trits 0 / 1
    assign w_trit = (r_sym < SYM_DATA) ? r_a[{r_sym[2:0], 1'b0} +: 2]
                                       : {2{r_d[r_sym[1:0]]}};

    assign w_units     = (r_state == ST_SYNC) ? (r_seg[0] ? SEG_SYNC_LOW : SEG_SHORT)
                                              : code_seg_units(w_trit, r_seg);
    assign w_seg_ticks = TW'(w_units) * TW'(A_TICKS);
    assign w_seg_end   = w_tick && (r_tcnt == w_seg_ticks - TW'(1));
    assign w_words_inc = (r_words == c_min_words) ? r_words : r_words + WW'(1);

    always_comb begin
        w_state_next = r_state;
        w_sym_next   = r_sym;
        w_seg_next   = r_seg;
        w_tcnt_next  = r_tcnt;
        w_words_next = r_words;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_latch      = 1'b0;
        w_div_clr    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (bus.te_i)
                    w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_latch      = 1'b1;
                w_sym_next   = '0;
                w_seg_next   = '0;
                w_tcnt_next  = '0;
                w_state_next = ST_BITS;
`ifdef PT2262_INVALID_TRIT_CHECK_EN
                if (has_invalid_trit(bus.a_i)) begin
                    w_err_next   = 1'b1;
                    w_words_next = '0;
                    w_state_next = ST_IDLE;
                end
`endif
            end
            ST_BITS: begin
                w_div_clr = 1'b0;
                if (w_seg_end) begin
                    w_tcnt_next = '0;
                    if (r_seg == SEG_LAST) begin
                        w_seg_next = '0;
                        if (r_sym == SYM_LAST) begin
                            w_sym_next   = '0;
                            w_state_next = ST_SYNC;
                        end else begin
                            w_sym_next = r_sym + 4'd1;
                        end
                    end else begin
                        w_seg_next = r_seg + 2'd1;
                    end
                end else if (w_tick) begin
                    w_tcnt_next = r_tcnt + TW'(1);
                end
            end
            ST_SYNC: begin
                w_div_clr = 1'b0;
                if (w_seg_end) begin
                    w_tcnt_next = '0;
                    if (r_seg == 2'd0) begin
                        w_seg_next = 2'd1;
                    end else begin
                        w_seg_next   = '0;
                        w_done_next  = 1'b1;
                        w_words_next = w_words_inc;
                        if ((w_words_inc < c_min_words) || bus.te_i) begin
                            w_state_next = ST_LOAD;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_words_next = '0;
                        end
                    end
                end else if (w_tick) begin
                    w_tcnt_next = r_tcnt + TW'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Even segments are high, odd segments low; the level is registered
        // together with the segment it belongs to so cod_o has no lag.
        w_cod_next = ((w_state_next == ST_BITS) || (w_state_next == ST_SYNC))
                     && !w_seg_next[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_d     <= '0;
            r_sym   <= '0;
            r_seg   <= '0;
            r_tcnt  <= '0;
            r_words <= '0;
            r_cod   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sym   <= w_sym_next;
            r_seg   <= w_seg_next;
            r_tcnt  <= w_tcnt_next;
            r_words <= w_words_next;
            r_cod   <= w_cod_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            if (w_latch) begin
                r_a <= bus.a_i;
                r_d <= bus.d_i;
            end
        end
    end

    assign bus.cod_o       = r_cod;
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.word_done_o = r_done;
    assign bus.err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pt2262_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pt2262_encoder
// Description : Self-checking bench for pt2262_encoder with DIV=2, A_TICKS=1
//               (a = 2 clk, code bit = 64 clk, word = 1024 + 1 clk).
//               u_dut1 has MIN_WORDS=1, u_dut4 has MIN_WORDS=4. Expected
//               waveforms come from a symbol-table model of the line.
// Macros      : PT2262_INVALID_TRIT_CHECK_EN selects the illegal-trit case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pt2262_encoder;

    localparam int A_CLK  = 2;     // clk cycles per unit a
    localparam int W_CLK  = 1024;  // clk cycles of one word's waveform

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pt2262_encoder_if ifc1 ();
    pt2262_encoder_if ifc4 ();

    pt2262_encoder #(.DIV(2), .A_TICKS(1), .MIN_WORDS(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(ifc1)
    );
    pt2262_encoder #(.DIV(2), .A_TICKS(1), .MIN_WORDS(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(ifc4)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_wave [W_CLK];

    typedef struct {
        logic [15:0] a;
        logic [3:0]  d;
        int          exp_high;   // high clk cycles in the whole word
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference line shape, straight from the symbol table
    task automatic build_wave(input logic [15:0] a, input logic [3:0] d);
        int pos;
        int lens [4];
        logic [1:0] t;
        pos = 0;
        for (int s = 0; s < 12; s++) begin
            if (s < 8) t = a[2*s +: 2];
            else       t = d[s-8] ? 2'b11 : 2'b00;
            case (t)
                2'b00:   lens = '{4, 12, 4, 12};
                2'b11:   lens = '{12, 4, 12, 4};
                default: lens = '{4, 12, 12, 4};
            endcase
            for (int g = 0; g < 4; g++)
                for (int k = 0; k < lens[g] * A_CLK; k++) begin
                    exp_wave[pos] = (g % 2 == 0);
                    pos++;
                end
        end
        for (int k = 0; k < 128 * A_CLK; k++) begin
            exp_wave[pos] = (k < 4 * A_CLK);
            pos++;
        end
    endtask

    // Called in the first waveform cycle of a word on u_dut1; ends in the
    // cycle after the word's last edge (word_done_o visible).
    task automatic check_wave(input logic [15:0] a, input logic [3:0] d,
                              input int chg_at, input logic [3:0] new_d,
                              input logic new_te, output int highs);
        int bad, first, wd;
        bad = 0; first = -1; wd = 0; highs = 0;
        build_wave(a, d);
        for (int i = 0; i < W_CLK; i++) begin
            if (i == chg_at) begin
                ifc1.d_i  = new_d;
                ifc1.te_i = new_te;
            end
            if (ifc1.cod_o !== exp_wave[i]) begin
                if (first < 0) first = i;
                bad++;
            end
            if (ifc1.cod_o === 1'b1) highs++;
            if (ifc1.word_done_o !== 1'b0) wd++;
            tick();
        end
        if (bad != 0) $display("first differing cycle %0d", first);
        chk("wave_bad_cycles", bad, 0);
        chk("word_done_early", wd, 0);
        chk("word_done_end", {31'd0, ifc1.word_done_o}, 1);
        chk("cod_after_sync", {31'd0, ifc1.cod_o}, 0);
    endtask

    task automatic run_word(input logic [15:0] a, input logic [3:0] d, output int highs);
        ifc1.a_i  = a;
        ifc1.d_i  = d;
        ifc1.te_i = 1'b1;
        tick();
        ifc1.te_i = 1'b0;
        chk("load_cod", {31'd0, ifc1.cod_o}, 0);
        chk("load_busy", {31'd0, ifc1.busy_o}, 1);
        tick();
        check_wave(a, d, -1, d, 1'b0, highs);
        chk("busy_end", {31'd0, ifc1.busy_o}, 0);
        tick();
        chk("word_done_width", {31'd0, ifc1.word_done_o}, 0);
    endtask

    initial begin
        int highs, cnt, wd;
        int pulses [$];
        logic [15:0] ra;

        vecs[0] = '{16'h0000, 4'b0000, 200};
        vecs[1] = '{16'hFB2C, 4'b1010, 424};   // trits 0,1,F,0,1,F,1,1
        vecs[2] = '{16'hFFFF, 4'b1111, 584};
        vecs[3] = '{16'hAAAA, 4'b0000, 328};
        vecs[4] = '{16'h00FF, 4'b0001, 360};

        reset = 1'b1;
        ifc1.a_i = '0; ifc1.d_i = '0; ifc1.te_i = 1'b0;
        ifc4.a_i = '0; ifc4.d_i = '0; ifc4.te_i = 1'b0;
        repeat (3) tick();
        chk("rst_cod", {31'd0, ifc1.cod_o}, 0);
        chk("rst_busy", {31'd0, ifc1.busy_o}, 0);
        chk("rst_done", {31'd0, ifc1.word_done_o}, 0);
        chk("rst_err", {31'd0, ifc1.err_o}, 0);
        chk("rst_cod4", {31'd0, ifc4.cod_o}, 0);
        reset = 1'b0;
        tick();

        // Table-driven words, te_i pulsed for a single clk
        for (int v = 0; v < 5; v++) begin
            run_word(vecs[v].a, vecs[v].d, highs);
            chk($sformatf("high_cycles_v%0d", v), highs, vecs[v].exp_high);
        end

        // Randomized legal words against the model
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(2))
                    0:       ra[2*k +: 2] = 2'b00;
                    1:       ra[2*k +: 2] = 2'b11;
                    default: ra[2*k +: 2] = 2'b10;
                endcase
            end
            run_word(ra, 4'($urandom), highs);
        end

        // Reset in the middle of BITS aborts the word
        ifc1.a_i = 16'h0000; ifc1.d_i = 4'h0; ifc1.te_i = 1'b1;
        tick();
        ifc1.te_i = 1'b0;
        tick();
        repeat (100) tick();
        chk("pre_reset_cod", {31'd0, ifc1.cod_o}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_cod", {31'd0, ifc1.cod_o}, 0);
        chk("abort_busy", {31'd0, ifc1.busy_o}, 0);
        chk("abort_done", {31'd0, ifc1.word_done_o}, 0);
        cnt = 0; wd = 0;
        for (int i = 0; i < 60; i++) begin
            if (ifc1.cod_o !== 1'b0) cnt++;
            if (ifc1.word_done_o !== 1'b0) wd++;
            tick();
        end
        chk("abort_idle_cod", cnt, 0);
        chk("abort_idle_done", wd, 0);

`ifdef PT2262_INVALID_TRIT_CHECK_EN
        // Illegal trit: err_o pulse, nothing sent
        ifc1.a_i = 16'h0001; ifc1.d_i = 4'h0; ifc1.te_i = 1'b1;
        tick();
        ifc1.te_i = 1'b0;
        chk("err_not_yet", {31'd0, ifc1.err_o}, 0);
        tick();
        chk("err_pulse", {31'd0, ifc1.err_o}, 1);
        chk("err_busy", {31'd0, ifc1.busy_o}, 0);
        tick();
        chk("err_width", {31'd0, ifc1.err_o}, 0);
        cnt = 0; wd = 0;
        for (int i = 0; i < 200; i++) begin
            if (ifc1.cod_o !== 1'b0) cnt++;
            if (ifc1.word_done_o !== 1'b0) wd++;
            tick();
        end
        chk("err_no_cod", cnt, 0);
        chk("err_no_done", wd, 0);
`else
        // Illegal trit 01 in A0 goes out as F
        run_word(16'h0001, 4'h0, highs);
        chk("invalid_as_f_highs", highs, 216);
        chk("err_tied_low", {31'd0, ifc1.err_o}, 0);
`endif

        // te_i held high: mid-word data change lands in the next word,
        // te_i falling mid-word still completes that word
        ifc1.a_i = 16'hFB2C; ifc1.d_i = 4'h0; ifc1.te_i = 1'b1;
        tick();
        tick();
        check_wave(16'hFB2C, 4'h0, 500, 4'hF, 1'b1, highs);
        chk("held_reload_busy", {31'd0, ifc1.busy_o}, 1);
        tick();
        check_wave(16'hFB2C, 4'hF, 300, 4'hF, 1'b0, highs);
        chk("held_end_busy", {31'd0, ifc1.busy_o}, 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (ifc1.cod_o !== 1'b0) cnt++;
            tick();
        end
        chk("held_after_idle", cnt, 0);

        // MIN_WORDS=4 with a single-clk te_i pulse
        ifc4.a_i = 16'hAAAA; ifc4.d_i = 4'h5; ifc4.te_i = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 4 * 1025 + 300; k++) begin
            tick();
            if (k == 1) ifc4.te_i = 1'b0;
            if (ifc4.word_done_o === 1'b1) pulses.push_back(k);
            if (k > 4 * 1025 + 1 && ifc4.cod_o !== 1'b0) cnt++;
        end
        chk("min4_pulses", pulses.size(), 4);
        if (pulses.size() == 4) begin
            chk("min4_first", pulses[0], 1026);
            for (int p = 1; p < 4; p++)
                chk($sformatf("min4_gap%0d", p), pulses[p] - pulses[p-1], 1025);
        end
        chk("min4_idle_cod", cnt, 0);
        chk("min4_idle_busy", {31'd0, ifc4.busy_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
